// File: rtl/qpsk_rx_framer.sv
// QPSK receive framer: hunts for the sync word in the dibit stream, reads a length byte and packs the payload into a byte FIFO.
// Optional CRC8 trailer check is compiled in when QPSK_RX_CRC8_EN is defined.
module qpsk_rx_framer #(
    parameter logic [31:0] SYNC_WORD  = 32'h0000_A5C3,
    parameter int          SYNC_BITS  = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       valid_x,
    input  logic [1:0] x,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       busy,
    output logic       overflow,
    output logic       crc_ok,
    output logic       crc_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SYNC_BITS-1:0] SYNC_PAT = SYNC_WORD[SYNC_BITS-1:0];

    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAY, S_CRC} state_t;

`ifdef QPSK_RX_CRC8_EN
    localparam state_t S_DONE = S_CRC;
`else
    localparam state_t S_DONE = S_HUNT;
`endif

    state_t               state_q, state_d;
    logic [SYNC_BITS-1:0] sr_q, sr_d;
    logic [1:0]           dcnt_q, dcnt_d;
    logic [5:0]           pack_q, pack_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 frame_start_q, frame_start_d;
    logic                 overflow_q, overflow_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]           mem_q [FIFO_DEPTH];

    logic       push;
    logic [8:0] push_word;
    logic       empty, full, pop, wr_en;
    logic [7:0] rx_byte;

    // Completed byte on the 4th dibit: three held dibits plus the current one
    assign rx_byte = {pack_q, x};

`ifdef QPSK_RX_CRC8_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        dcnt_d        = dcnt_q;
        pack_d        = pack_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        push          = 1'b0;
        push_word     = {rx_byte, 1'b0};
`ifdef QPSK_RX_CRC8_EN
        crc_d     = crc_q;
        crc_ok_d  = 1'b0;
        crc_err_d = 1'b0;
`endif
        if (valid_x) begin
            case (state_q)
                S_HUNT: begin
                    sr_d = SYNC_BITS'({sr_q, x});
                    if (sr_d == SYNC_PAT) begin
                        frame_start_d = 1'b1;
                        sr_d          = '0;
                        dcnt_d        = 2'd0;
                        state_d       = S_LEN;
`ifdef QPSK_RX_CRC8_EN
                        crc_d = 8'h00;
`endif
                    end
                end
                S_LEN: begin
                    dcnt_d = dcnt_q + 2'd1;
                    pack_d = {pack_q[3:0], x};
                    if (dcnt_q == 2'd3) begin
                        cnt_d   = rx_byte;
                        state_d = (rx_byte == 8'h00) ? S_DONE : S_PAY;
`ifdef QPSK_RX_CRC8_EN
                        crc_d = crc8_upd(crc_q, rx_byte);
`endif
                    end
                end
                S_PAY: begin
                    dcnt_d = dcnt_q + 2'd1;
                    pack_d = {pack_q[3:0], x};
                    if (dcnt_q == 2'd3) begin
                        push      = 1'b1;
                        push_word = {rx_byte, cnt_q == 8'd1};
                        cnt_d     = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_d = S_DONE;
                        end
`ifdef QPSK_RX_CRC8_EN
                        crc_d = crc8_upd(crc_q, rx_byte);
`endif
                    end
                end
`ifdef QPSK_RX_CRC8_EN
                S_CRC: begin
                    dcnt_d = dcnt_q + 2'd1;
                    pack_d = {pack_q[3:0], x};
                    if (dcnt_q == 2'd3) begin
                        crc_ok_d  = (rx_byte == crc_q);
                        crc_err_d = (rx_byte != crc_q);
                        state_d   = S_HUNT;
                    end
                end
`endif
                default: state_d = S_HUNT;
            endcase
        end
    end

    // FIFO: pop is resolved before the write, so a full FIFO being drained still accepts a byte
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && byte_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (push && full && !pop);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= S_HUNT;
            sr_q          <= '0;
            dcnt_q        <= 2'd0;
            cnt_q         <= 8'd0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            dcnt_q        <= dcnt_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLK) begin
        pack_q <= pack_d;
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

`ifdef QPSK_RX_CRC8_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_q     <= 8'h00;
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_ok_q  <= crc_ok_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_ok  = crc_ok_q;
    assign crc_err = crc_err_q;
`else
    assign crc_ok  = 1'b0;
    assign crc_err = 1'b0;
`endif

    assign byte_valid  = !empty;
    assign byte_data   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]][8:1];
    assign byte_last   = empty ? 1'b0  : mem_q[rd_ptr_q[AW-1:0]][0];
    assign frame_start = frame_start_q;
    assign busy        = (state_q != S_HUNT);
    assign overflow    = overflow_q;

endmodule
